// File: rtl/cpu_trace_uart_tx.sv
// Trace transmitter: captures {pc, r7} on r7 change or snapshot request and
// sends it as a 4-byte 8N1 UART frame, with a single pending-capture slot.
module cpu_trace_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  pc_in,
    input  logic [15:0] r7_in,
    input  logic        snap_req,
    output logic        tx,
    output logic        busy,
    output logic        pending,
    output logic [7:0]  drop_count
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]    r_bit_idx, w_bit_next;
    logic [1:0]    r_byte_idx, w_byte_next;
    logic [20:0]   r_frame, w_frame_next;
    logic [20:0]   r_pbuf, w_pbuf_next;
    logic          r_pending, w_pending_next;
    logic [7:0]    r_drop, w_drop_next;
    logic [15:0]   r_r7_prev;
    logic          r_tx, w_tx_next;
    logic          r_busy;
    logic          w_event;
    logic          w_bit_end;
    logic [20:0]   w_cap;
    logic [7:0]    w_byte_next_val;

    function automatic logic [7:0] sel_byte(input logic [20:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_byte = SYNC_BYTE;
            2'd1:    sel_byte = {3'b000, word[20:16]};
            2'd2:    sel_byte = word[15:8];
            default: sel_byte = word[7:0];
        endcase
    endfunction

    assign w_event   = (r7_in != r7_prev_w()) | snap_req;
    assign w_bit_end = (r_cnt == LAST_CNT);
    assign w_cap     = {pc_in, r7_in};

    function automatic logic [15:0] r7_prev_w();
        r7_prev_w = r_r7_prev;
    endfunction

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_next     = r_bit_idx;
        w_byte_next    = r_byte_idx;
        w_frame_next   = r_frame;
        w_pbuf_next    = r_pbuf;
        w_pending_next = r_pending;
        w_drop_next    = r_drop;

        if (r_state == S_IDLE) begin
            // Draining the slot frees it, so a same-edge event refills it without a drop.
            if (r_pending || w_event) begin
                w_state_next = S_START;
                w_cnt_next   = '0;
                w_byte_next  = 2'd0;
                w_bit_next   = 3'd0;
                if (r_pending) begin
                    w_frame_next   = r_pbuf;
                    w_pending_next = w_event;
                    if (w_event)
                        w_pbuf_next = w_cap;
                end else begin
                    w_frame_next = w_cap;
                end
            end
        end else begin
            if (w_event) begin
                w_pbuf_next    = w_cap;
                w_pending_next = 1'b1;
                if (r_pending && (r_drop != 8'hFF))
                    w_drop_next = r_drop + 8'd1;
            end
            if (w_bit_end) begin
                w_cnt_next = '0;
                case (r_state)
                    S_START: begin
                        w_state_next = S_DATA;
                        w_bit_next   = 3'd0;
                    end
                    S_DATA: begin
                        if (r_bit_idx == 3'd7)
                            w_state_next = S_STOP;
                        else
                            w_bit_next = r_bit_idx + 3'd1;
                    end
                    default: begin
                        if (r_byte_idx != 2'd3) begin
                            w_byte_next  = r_byte_idx + 2'd1;
                            w_state_next = S_START;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                endcase
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    // Line level is computed from the next state so tx moves on the same edge as the FSM.
    always_comb begin
        w_byte_next_val = sel_byte(w_frame_next, w_byte_next);
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_byte_next_val[w_bit_next];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_frame    <= '0;
            r_pbuf     <= '0;
            r_pending  <= 1'b0;
            r_drop     <= '0;
            r_r7_prev  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit_idx  <= w_bit_next;
            r_byte_idx <= w_byte_next;
            r_frame    <= w_frame_next;
            r_pbuf     <= w_pbuf_next;
            r_pending  <= w_pending_next;
            r_drop     <= w_drop_next;
            r_r7_prev  <= r7_in;
            r_tx       <= w_tx_next;
            r_busy     <= (w_state_next != S_IDLE);
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign pending    = r_pending;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_cpu_trace_uart_tx.sv
// Directed bench for cpu_trace_uart_tx with CLKS_PER_BIT=4; line samples are
// compared cycle-by-cycle against hand-specified frame bytes.
module tb_cpu_trace_uart_tx;

    localparam int unsigned CPB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  pc_in = '0;
    logic [15:0] r7_in = '0;
    logic        snap_req = 1'b0;
    logic        tx;
    logic        busy;
    logic        pending;
    logic [7:0]  drop_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    cpu_trace_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pc_in     (pc_in),
        .r7_in     (r7_in),
        .snap_req  (snap_req),
        .tx        (tx),
        .busy      (busy),
        .pending   (pending),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // 40-cycle line pattern of one 8N1 byte, sample k at index k.
    function automatic logic [39:0] pat(input logic [7:0] b);
        logic [39:0] v;
        int bi;
        v = '0;
        for (int k = 0; k < 40; k++) begin
            bi = k / CPB;
            if (bi == 0)      v[k] = 1'b0;
            else if (bi == 9) v[k] = 1'b1;
            else              v[k] = b[bi-1];
        end
        return v;
    endfunction

    // Called just after the edge on which the start bit began; returns at k=160.
    task automatic rx_frame(input string tag, input logic [31:0] exp_bytes);
        logic [159:0] s;
        logic [7:0]   eb;
        for (int k = 0; k < 160; k++) begin
            s[k] = tx;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            eb = exp_bytes[31-8*i -: 8];
            chk($sformatf("%s_byte%0d", tag, i), 64'(s[i*40 +: 40]), 64'(pat(eb)));
        end
    endtask

    initial begin
        // 1: reset and quiet idle
        repeat (3) tick();
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (20) tick();
        chk("idle_tx", 64'(tx), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_pend", 64'(pending), 64'd0);
        chk("idle_drop", 64'(drop_count), 64'd0);

        // 2: r7 change starts a frame on the same edge
        pc_in = 5'h03; r7_in = 16'h1234;
        tick();
        chk("f1_tx_fall", 64'(tx), 64'd0);
        chk("f1_busy", 64'(busy), 64'd1);
        rx_frame("f1", 32'hA5_03_12_34);
        chk("f1_end_busy", 64'(busy), 64'd0);
        chk("f1_end_tx", 64'(tx), 64'd1);
        chk("f1_end_pend", 64'(pending), 64'd0);

        // 3: mid-frame change goes to pending and drains after one idle cycle
        pc_in = 5'h02; r7_in = 16'h00AA;
        tick();
        fork
            rx_frame("f2", 32'hA5_02_00_AA);
            begin
                repeat (50) tick();
                pc_in = 5'h04; r7_in = 16'hBEEF;
                tick();
                chk("f2_pend_set", 64'(pending), 64'd1);
                chk("f2_drop0", 64'(drop_count), 64'd0);
            end
        join
        chk("f2_gap_busy", 64'(busy), 64'd0);
        chk("f2_gap_tx", 64'(tx), 64'd1);
        chk("f2_gap_pend", 64'(pending), 64'd1);
        tick();
        chk("f3_pend_clr", 64'(pending), 64'd0);
        chk("f3_busy", 64'(busy), 64'd1);

        // 4: two changes while busy, second overwrites and counts one drop
        fork
            rx_frame("f3", 32'hA5_04_BE_EF);
            begin
                repeat (30) tick();
                r7_in = 16'h0001;
                tick();
                chk("f3_pend_a", 64'(pending), 64'd1);
                chk("f3_drop_a", 64'(drop_count), 64'd0);
                repeat (30) tick();
                r7_in = 16'h0002;
                tick();
                chk("f3_pend_b", 64'(pending), 64'd1);
                chk("f3_drop_b", 64'(drop_count), 64'd1);
            end
        join
        chk("f3_gap_pend", 64'(pending), 64'd1);
        tick();
        rx_frame("f4", 32'hA5_04_00_02);
        chk("f4_end_pend", 64'(pending), 64'd0);
        chk("f4_end_busy", 64'(busy), 64'd0);
        chk("f4_drop", 64'(drop_count), 64'd1);

        // 5: snapshot with unchanged r7, then snapshot coincident with a change
        pc_in = 5'h1F; r7_in = 16'h00FF;
        tick();
        rx_frame("f5", 32'hA5_1F_00_FF);
        repeat (5) tick();
        chk("f5_idle_busy", 64'(busy), 64'd0);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("snap_tx_fall", 64'(tx), 64'd0);
        rx_frame("f6", 32'hA5_1F_00_FF);
        repeat (3) tick();
        r7_in = 16'h0100; snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        rx_frame("f7", 32'hA5_1F_01_00);
        chk("f7_end_pend", 64'(pending), 64'd0);
        repeat (10) tick();
        chk("f7_single_busy", 64'(busy), 64'd0);
        chk("f7_drop", 64'(drop_count), 64'd1);

        // 6: async reset in the middle of byte 2, bit 5
        pc_in = 5'h0A; r7_in = 16'h4321;
        tick();
        repeat (40) tick();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("f8_pend_set", 64'(pending), 64'd1);
        repeat (64) tick();
        chk("f8_b2_bit5", 64'(tx), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_tx", 64'(tx), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_pend", 64'(pending), 64'd0);
        chk("arst_drop", 64'(drop_count), 64'd0);
        tick();
        tick();
        chk("arst_hold_tx", 64'(tx), 64'd1);
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd1);
        rx_frame("f9", 32'hA5_0A_43_21);
        chk("f9_end_busy", 64'(busy), 64'd0);
        chk("f9_end_pend", 64'(pending), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_trace_uart_tx.md
Name: cpu_trace_uart_tx

Overview:
Trace transmitter that sits beside cpu_core and consumes its PC_out and r7_data outputs.
- Whenever r7 changes value, or on an explicit snapshot request, it captures {PC, r7}.
- It serialises the capture as a 4-byte frame on a UART 8N1 line for an off-board host.
- One pending-capture buffer absorbs events that arrive while a frame is in flight. Overflow is counted.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_in  input  5  program counter from core (PC_out)
r7_in  input  16  register r7 value from core (r7_data)
snap_req  input  1  single-cycle pulse; forces a capture of current pc_in/r7_in
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is being shifted out
pending  output  1  high while a capture waits for the line
drop_count  output  8  saturating count of overwritten pending captures

Behaviour:
Reset (async, active-high): immediate effect on assertion, including mid-frame.
- tx=1, busy=0, pending=0, drop_count=0.
- r7_prev=0, FSM=IDLE, all counters 0.

Event detection:
- r7_prev <= r7_in every cycle.
- event = (r7_in != r7_prev) | snap_req.
- A change and snap_req in the same cycle produce one event.

Capture: the captured word is {pc_in, r7_in} as sampled at the event edge.
- event while IDLE and !pending: load shift buffer, FSM->START, tx=0 from that edge. Latency is 0 cycles after the event edge.
- event while busy and !pending: store into pending buffer, pending=1.
- event while pending=1: overwrite pending buffer with the newest capture; drop_count+1, saturating at 255.

Frame format: 4 bytes, sent in order.
- Byte 0: SYNC_BYTE.
- Byte 1: {3'b000, pc}.
- Byte 2: r7[15:8].
- Byte 3: r7[7:0].

Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. Bytes are back-to-back with no idle gap. A frame is 40*CLKS_PER_BIT cycles.

FSM states:
- IDLE: tx=1, busy=0. On event, or pending=1, go to START.
- START: tx=0. When the bit counter reaches CLKS_PER_BIT-1, go to DATA with bit_idx=0.
- DATA: tx=byte[bit_idx]. At the end of each bit, bit_idx+1. After bit 7, go to STOP.
- STOP: tx=1. At the end of the bit:
  - if byte_idx<3: byte_idx+1, go to START.
  - else: go to IDLE.
- busy=1 in START/DATA/STOP.

Pending drain: after the last stop bit, the FSM spends exactly one cycle in IDLE (tx=1). If pending=1, the next edge loads the pending buffer, clears pending and enters START. An event occurring on that same edge goes into pending.

Bit counter: width clog2(CLKS_PER_BIT). It resets to 0 on every bit boundary and never wraps mid-bit.

Outputs are registered. tx must be driven from a flop with no combinational glitching.

Test Plan:
CLKS_PER_BIT=4 for all tests.
1. Reset, hold r7_in=0 → tx=1, busy=0 indefinitely, drop_count=0.
2. pc_in=5'h03, r7_in 0→16'h1234 → tx falls on the same edge. The line carries bytes A5, 03, 12, 34 (LSB first, 8N1) over 160 cycles. busy deasserts after the last stop bit.
3. Mid-frame, r7_in→16'hBEEF with pc_in=5'h04 → pending=1. One idle cycle after frame 1, a second frame A5, 04, BE, EF is sent; pending clears.
4. While busy, two further changes (16'h0001, then 16'h0002) → drop_count=1. The second frame carries 00, 02 in its last two bytes.
5. snap_req pulse with r7_in unchanged (16'h00FF, pc 5'h1F) → frame A5, 1F, 00, FF. A snap_req coincident with an r7 change yields exactly one frame.
6. Assert reset at bit 5 of byte 2 → tx=1 asynchronously, busy=0, pending=0. After release with r7_in equal to its pre-reset non-zero value, a new frame starts, because r7_prev was reset to 0.
